// File: rtl/calc_seq_unit_if.sv
// Request/response valid-ready channel for calc_seq_unit.
// The status field exists only when CALC_STATUS_EN is defined.
interface calc_seq_unit_if #(
  parameter int WIDTH  = 64,
  parameter int MODE_W = 4
);

  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic [MODE_W-1:0] mode;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  result;
  logic              busy;

`ifdef CALC_STATUS_EN
  logic [2:0]        status;

  modport master (
    output in_valid, a, b, mode, out_ready,
    input  in_ready, out_valid, result, busy, status
  );

  modport slave (
    input  in_valid, a, b, mode, out_ready,
    output in_ready, out_valid, result, busy, status
  );
`else
  modport master (
    output in_valid, a, b, mode, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, a, b, mode, out_ready,
    output in_ready, out_valid, result, busy
  );
`endif

endinterface

// File: rtl/calc_seq_unit.sv
// Sequential add/sub/mul/div/rem unit; mul and div/rem iterate one bit per cycle.
// Define CALC_STATUS_EN to add the zero/carry/div-by-zero status flags.
module calc_seq_unit #(
  parameter int  WIDTH  = 64,
  parameter int  MODE_W = 4,
  localparam int CNT_W  = $clog2(WIDTH) + 1
) (
  input  logic           clk,
  input  logic           rst,
  calc_seq_unit_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ITER = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [MODE_W-1:0] MODE_ADD = MODE_W'(0);
  localparam logic [MODE_W-1:0] MODE_SUB = MODE_W'(1);
  localparam logic [MODE_W-1:0] MODE_MUL = MODE_W'(2);
  localparam logic [MODE_W-1:0] MODE_DIV = MODE_W'(3);
  localparam logic [MODE_W-1:0] MODE_REM = MODE_W'(4);

  // The product high half is only needed to report multiply overflow.
`ifdef CALC_STATUS_EN
  localparam int ACC_W = 2 * WIDTH;
`else
  localparam int ACC_W = WIDTH;
`endif

  logic [1:0]        state;
  logic [CNT_W-1:0]  counter;
  logic [MODE_W-1:0] mode_q;
  logic [WIDTH-1:0]  result_q;

  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_nxt;
  logic [ACC_W-1:0]  mcand;
  logic [WIDTH-1:0]  mplier;

  logic [WIDTH-1:0]  quo;
  logic [WIDTH-1:0]  quo_nxt;
  logic [WIDTH-1:0]  rem;
  logic [WIDTH-1:0]  rem_nxt;
  logic [WIDTH-1:0]  divisor;
  logic [WIDTH:0]    shifted;
  logic [WIDTH:0]    trial;

  logic [WIDTH-1:0]  sum;
  logic [WIDTH-1:0]  diff;
  logic              last_iter;
  logic [WIDTH-1:0]  iter_result;

`ifdef CALC_STATUS_EN
  logic              add_carry;
  assign {add_carry, sum} = {1'b0, bus.a} + {1'b0, bus.b};
`else
  assign sum = bus.a + bus.b;
`endif
  assign diff = bus.a - bus.b;

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.result    = result_q;

  assign last_iter = (counter == CNT_W'(WIDTH - 1));

  // One step of shift-add multiply and of restoring division. A set top bit
  // of the trial difference means it borrowed; with a zero divisor it never
  // does, giving an all-ones quotient and the dividend as remainder.
  always_comb begin
    acc_nxt = mplier[0] ? (acc + mcand) : acc;
    shifted = {rem, quo[WIDTH-1]};
    trial   = shifted - {1'b0, divisor};
    if (!trial[WIDTH]) begin
      rem_nxt = trial[WIDTH-1:0];
      quo_nxt = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_nxt = shifted[WIDTH-1:0];
      quo_nxt = {quo[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    case (mode_q)
      MODE_MUL: iter_result = acc_nxt[WIDTH-1:0];
      MODE_DIV: iter_result = quo_nxt;
      default:  iter_result = rem_nxt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      counter  <= '0;
      mode_q   <= '0;
      result_q <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      quo      <= '0;
      rem      <= '0;
      divisor  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            mode_q  <= bus.mode;
            counter <= '0;
            case (bus.mode)
              MODE_ADD: begin
                result_q <= sum;
                state    <= DONE;
              end
              MODE_SUB: begin
                result_q <= diff;
                state    <= DONE;
              end
              MODE_MUL, MODE_DIV, MODE_REM: begin
                acc     <= '0;
                mcand   <= ACC_W'(bus.a);
                mplier  <= bus.b;
                quo     <= bus.a;
                rem     <= '0;
                divisor <= bus.b;
                state   <= ITER;
              end
              default: begin
                result_q <= '0;
                state    <= DONE;
              end
            endcase
          end
        end
        ITER: begin
          counter <= counter + CNT_W'(1);
          acc     <= acc_nxt;
          mcand   <= mcand << 1;
          mplier  <= mplier >> 1;
          quo     <= quo_nxt;
          rem     <= rem_nxt;
          if (last_iter) begin
            result_q <= iter_result;
            state    <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CALC_STATUS_EN
  logic [2:0] status_q;

  // Flags are written on the same edge as the result they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      status_q <= '0;
    end else if (state == IDLE && bus.in_valid) begin
      case (bus.mode)
        MODE_ADD:                     status_q <= {1'b0, add_carry, sum == '0};
        MODE_SUB:                     status_q <= {1'b0, bus.a < bus.b, diff == '0};
        MODE_MUL, MODE_DIV, MODE_REM: status_q <= '0;
        default:                      status_q <= 3'b001;
      endcase
    end else if (state == ITER && last_iter) begin
      status_q <= {(mode_q != MODE_MUL) && (divisor == '0),
                   (mode_q == MODE_MUL) && (|acc_nxt[ACC_W-1:WIDTH]),
                   iter_result == '0};
    end
  end

  assign bus.status = status_q;
`endif

endmodule

// File: tb/tb_calc_seq_unit.sv
// Scoreboard bench for calc_seq_unit: expectations come from a behavioural model
// of each operation and are popped when the unit presents its result.
module tb_calc_seq_unit;

  localparam int W  = 64;
  localparam int MW = 4;

  typedef struct {
    logic [W-1:0] res;
    logic [2:0]   st;
    int           lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  calc_seq_unit_if #(.WIDTH(W), .MODE_W(MW)) bus ();

  calc_seq_unit #(.WIDTH(W), .MODE_W(MW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic checkOutput(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h", tag, got, want);
    end
  endtask

  function automatic exp_t model(input logic [MW-1:0] m, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t           e;
    logic [W:0]     s;
    logic [2*W-1:0] prod;
    e.st  = 3'b000;
    e.lat = 1;
    case (m)
      4'd0: begin
        s       = {1'b0, x} + {1'b0, y};
        e.res   = s[W-1:0];
        e.st[1] = s[W];
      end
      4'd1: begin
        e.res   = x - y;
        e.st[1] = (x < y);
      end
      4'd2: begin
        prod    = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        e.res   = prod[W-1:0];
        e.st[1] = (prod[2*W-1:W] != '0);
        e.lat   = W + 1;
      end
      4'd3: begin
        e.res   = (y == '0) ? {W{1'b1}} : x / y;
        e.st[2] = (y == '0);
        e.lat   = W + 1;
      end
      4'd4: begin
        e.res   = (y == '0) ? x : x % y;
        e.st[2] = (y == '0);
        e.lat   = W + 1;
      end
      default: e.res = '0;
    endcase
    e.st[0] = (e.res == '0);
    return e;
  endfunction

  task automatic startOp(input logic [MW-1:0] m, input logic [W-1:0] x, input logic [W-1:0] y, input bit push);
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("in_ready_before_accept", 64'(bus.in_ready), 64'(1));
    bus.mode     = m;
    bus.a        = x;
    bus.b        = y;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a        = {$urandom, $urandom};
    bus.b        = {$urandom, $urandom};
    bus.mode     = 4'(MW'($urandom_range(0, 15)));
    if (push) sb.push_back(model(m, x, y));
  endtask

  task automatic collectOp(input int stall, input bit poke);
    exp_t         e;
    int           edges    = 1;
    int           busy_low = 0;
    logic [W-1:0] held;
    while (bus.out_valid !== 1'b1 && edges < 3 * W) begin
      if (bus.busy !== 1'b1) busy_low++;
      @(posedge clk); #1;
      edges++;
    end
    if (sb.size() == 0) begin
      checkOutput("scoreboard_nonempty", 64'(sb.size()), 64'(1));
      return;
    end
    e = sb.pop_front();
    checkOutput("latency", 64'(edges), 64'(e.lat));
    checkOutput("busy_while_iterating", 64'(busy_low), 64'(0));
    held = bus.result;
    for (int i = 0; i < stall; i++) begin
      if (poke && i == 3) begin
        bus.mode     = 4'd0;
        bus.a        = 64'd7;
        bus.b        = 64'd8;
        bus.in_valid = 1'b1;
      end
      if (poke && i == 4) bus.in_valid = 1'b0;
      @(posedge clk); #1;
      checkOutput("stall_result", bus.result, held);
      checkOutput("stall_out_valid", 64'(bus.out_valid), 64'(1));
      checkOutput("stall_in_ready", 64'(bus.in_ready), 64'(0));
    end
    checkOutput("result", bus.result, e.res);
`ifdef CALC_STATUS_EN
    checkOutput("status", 64'(bus.status), 64'(e.st));
`endif
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checkOutput("after_xfer_out_valid", 64'(bus.out_valid), 64'(0));
    checkOutput("after_xfer_in_ready", 64'(bus.in_ready), 64'(1));
    if (poke) begin
      @(posedge clk); #1;
      checkOutput("ignored_op_out_valid", 64'(bus.out_valid), 64'(0));
      checkOutput("ignored_op_busy", 64'(bus.busy), 64'(0));
    end
  endtask

  task automatic applyStimulus(input logic [MW-1:0] m, input logic [W-1:0] x, input logic [W-1:0] y,
                               input int stall, input bit poke);
    startOp(m, x, y, 1'b1);
    collectOp(stall, poke);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.mode      = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", 64'(bus.in_ready), 64'(1));
    checkOutput("reset_out_valid", 64'(bus.out_valid), 64'(0));
    checkOutput("reset_result", bus.result, 64'(0));
    checkOutput("reset_busy", 64'(bus.busy), 64'(0));
`ifdef CALC_STATUS_EN
    checkOutput("reset_status", 64'(bus.status), 64'(0));
`endif
    rst = 1'b0;

    applyStimulus(4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 1'b0);
    applyStimulus(4'd2, 64'h1_0000_0001, 64'd3, 0, 1'b0);
    applyStimulus(4'd3, 64'd100, 64'd7, 0, 1'b0);
    applyStimulus(4'd4, 64'd100, 64'd7, 0, 1'b0);
    applyStimulus(4'd3, 64'd5, 64'd0, 0, 1'b0);
    applyStimulus(4'd4, 64'd5, 64'd0, 0, 1'b0);
    applyStimulus(4'd1, 64'd3, 64'd5, 10, 1'b1);

    startOp(4'd2, 64'h1234_5678_9ABC_DEF0, 64'hFFFF, 1'b0);
    repeat (29) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("midop_reset_out_valid", 64'(bus.out_valid), 64'(0));
    checkOutput("midop_reset_result", bus.result, 64'(0));
    checkOutput("midop_reset_in_ready", 64'(bus.in_ready), 64'(1));
    checkOutput("midop_reset_busy", 64'(bus.busy), 64'(0));
    applyStimulus(4'd0, 64'd2, 64'd2, 0, 1'b0);

    applyStimulus(4'd9, 64'hDEAD_BEEF, 64'h1234, 0, 1'b0);
    applyStimulus(4'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2, 1'b0);
    applyStimulus(4'd3, 64'h8000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      logic [MW-1:0] m;
      logic [W-1:0]  x;
      logic [W-1:0]  y;
      m = 4'($urandom_range(0, 5));
      x = {$urandom, $urandom};
      y = (i % 3 == 0) ? 64'($urandom_range(0, 9)) : {$urandom, $urandom};
      applyStimulus(m, x, y, $urandom_range(0, 2), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/calc_seq_unit.md
Name: calc_seq_unit

Overview:
- Parametrised, clocked successor to the combinational arithmetic calculator.
- Accepts one operation at a time on a valid/ready input channel and returns the result on a valid/ready output channel.
- Add/sub complete in one cycle. Multiply, divide and remainder use iterative shift-add / restoring datapaths instead of wide combinational arrays.
- Sits between the operand-issue logic and the result consumer; replaces the free-running combinational calculator path.

Parameters:
WIDTH, 64, operand/result width in bits (>=8)
MODE_W, 4, width of mode field
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  operation request valid
in_ready  output  1  unit can accept an operation
a  input  WIDTH  operand A (unsigned)
b  input  WIDTH  operand B (unsigned)
mode  input  MODE_W  0 add, 1 sub, 2 mul, 3 div, 4 rem, others invalid
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  WIDTH  operation result
busy  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous and active-high.
- Reset values: in_ready=1, out_valid=0, result=0, busy=0, state=IDLE, counter=0.
- States: IDLE, ITER, DONE.
- Handshake:
  - Accept when in_valid && in_ready at an edge; a, b and mode are registered at that edge.
  - in_ready = (state==IDLE).
  - Output transfer when out_valid && out_ready. result and out_valid are held stable until transfer.
- IDLE, on accept:
  - mode 0: result<=a+b, mod 2^WIDTH, carry dropped. Go to DONE.
  - mode 1: result<=a-b, mod 2^WIDTH, borrow dropped. Go to DONE.
  - mode 2/3/4: load internal operand/accumulator registers, counter<=0, go to ITER.
  - invalid mode: result<=0, go to DONE.
- ITER runs exactly WIDTH cycles; counter increments each cycle. On the cycle counter==WIDTH-1, write result and go to DONE.
  - mul: radix-2 shift-add. Result is the low WIDTH bits of the product.
  - div/rem: unsigned restoring division, one quotient bit per cycle. mode 3 returns the quotient; mode 4 returns the remainder.
- DONE: out_valid=1. On out_ready, go to IDLE next edge.
  - out_valid drops on that edge and in_ready rises on that edge.
  - No same-cycle re-accept.
- Latency (accept edge = T):
  - add/sub/invalid: out_valid high after edge T+1.
  - mul/div/rem: out_valid high after edge T+WIDTH+1.
  - Latency is fixed and independent of operand values.
- Divide by zero (b==0): no special path. The restoring algorithm must naturally yield quotient = all ones and remainder = a; the latency is unchanged.
- Back-pressure: if out_ready stays low, stay in DONE indefinitely with result stable; in_ready stays 0.
- Input while busy: in_valid with in_ready=0 is ignored; no state change, no operand capture.
- Reset mid-operation: rst in ITER or DONE returns to IDLE next edge and discards the partial result. out_valid=0, result=0 on that edge. rst has priority over every other event on the same edge.
- Operands changing after accept have no effect.

Optional Feature:
- Macro: CALC_STATUS_EN.
- When defined, adds output port `status` [2:0], registered alongside result and valid with out_valid:
  - bit0 zero: result==0.
  - bit1 carry/overflow:
    - add carry-out.
    - sub borrow (a<b).
    - mul: upper WIDTH bits of the full product nonzero. The multiplier must retain the high half, so the accumulator is 2*WIDTH.
  - bit2 div_by_zero: mode 3/4 with b==0.
  - Reset value 0. Invalid mode gives status=3'b001.
- When undefined: the port is absent, the multiplier keeps only the low WIDTH product bits, and there is no status logic.

Test Plan:
- WIDTH=64, mode 0, a=0xFFFF_FFFF_FFFF_FFFF, b=1, out_ready=1 -> out_valid one edge after accept, result=0. Status (if EN) = 3'b011.
- mode 2, a=0x1_0000_0001, b=3 -> out_valid exactly 65 edges after accept, result=0x3_0000_0003, busy high throughout.
- mode 3 a=100 b=7 -> result=14; mode 4 same operands -> result=2. mode 3 a=5 b=0 -> result=0xFFFF_FFFF_FFFF_FFFF; mode 4 a=5 b=0 -> result=5. Status bit2 set for both b==0 cases (if EN).
- mode 1 a=3 b=5 with out_ready held low 10 cycles -> result=0xFFFF_FFFF_FFFF_FFFE held stable, in_ready=0, and a second in_valid during the stall is ignored. After out_ready, one transfer, then in_ready=1.
- mode 2 accepted, rst asserted at iteration 30 -> next edge: IDLE, out_valid=0, result=0, in_ready=1. A new mode 0 op (2+2) then returns 4 with normal latency.
- mode 9, any operands -> result=0, out_valid one edge after accept.
